// File: rtl/tau_gemm_sched_pkg.sv
// Shared types and width helpers for the tau_gemm_sched GEMM array scheduler.
// Optional feature macro: TAU_SCHED_STEP_DONE_HS_EN (array-driven step completion).
package tau_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  // Bits needed to index 'count' distinct values, never less than one bit.
  function automatic int idx_w(input int count);
    if (count <= 2) begin
      return 1;
    end else begin
      return $clog2(count);
    end
  endfunction

  function automatic int req_w(input int num_req);
    return idx_w(num_req);
  endfunction

  function automatic int kidx_w(input int dim);
    return idx_w(dim);
  endfunction

  function automatic int klen_w(input int dim);
    return idx_w(dim + 1);
  endfunction

  function automatic int cyc_w(input int step_cycles);
    return idx_w(step_cycles);
  endfunction

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DIM     = 16;
  localparam int DEF_WIDTH   = 8;
  localparam int REQ_W       = req_w(DEF_NUM_REQ);
  localparam int KIDX_W      = kidx_w(DEF_DIM);
  localparam int KLEN_W      = klen_w(DEF_DIM);
  localparam int CYC_W       = cyc_w(DEF_WIDTH);

endpackage

// File: rtl/tau_gemm_sched_if.sv
// Requester, array-control and response signals of tau_gemm_sched.
// master: the scheduler; slave: requesters, operand muxes and response consumer.
// Optional feature macro: TAU_SCHED_STEP_DONE_HS_EN adds arr_step_done.
interface tau_gemm_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int DIM     = 16
);
  import tau_sched_pkg::*;

  localparam int RW  = req_w(NUM_REQ);
  localparam int KIW = kidx_w(DIM);
  localparam int KLW = klen_w(DIM);

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0][KLW-1:0] req_klen;
  logic [NUM_REQ-1:0]          req_ready;
  logic [RW-1:0]               arr_sel;
  logic [KIW-1:0]              arr_k_idx;
  logic                        arr_clear;
  logic                        arr_start;
  logic                        rsp_valid;
  logic [RW-1:0]               rsp_id;
  logic                        rsp_ready;
  logic                        busy;
`ifdef TAU_SCHED_STEP_DONE_HS_EN
  logic                        arr_step_done;
`endif

  modport master (
    input  req_valid, req_klen, rsp_ready,
`ifdef TAU_SCHED_STEP_DONE_HS_EN
    input  arr_step_done,
`endif
    output req_ready, arr_sel, arr_k_idx, arr_clear, arr_start,
    output rsp_valid, rsp_id, busy
  );

  modport slave (
    output req_valid, req_klen, rsp_ready,
`ifdef TAU_SCHED_STEP_DONE_HS_EN
    output arr_step_done,
`endif
    input  req_ready, arr_sel, arr_k_idx, arr_clear, arr_start,
    input  rsp_valid, rsp_id, busy
  );

endinterface

// File: rtl/tau_gemm_sched_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above rr_ptr, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int REQ_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [REQ_W-1:0]   rr_ptr,
  output logic               any_grant,
  output logic [REQ_W-1:0]   grant_idx,
  output logic [NUM_REQ-1:0] grant_oh
);

  logic [REQ_W-1:0] cand_s;

  // Walk candidates from rr_ptr upward; the first one requesting wins.
  always_comb begin
    any_grant = 1'b0;
    grant_idx = {REQ_W{1'b0}};
    grant_oh  = {NUM_REQ{1'b0}};
    cand_s    = {REQ_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = REQ_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!any_grant && req[cand_s]) begin
        any_grant        = 1'b1;
        grant_idx        = cand_s;
        grant_oh[cand_s] = 1'b1;
      end else begin
        any_grant = any_grant;
      end
    end
  end

endmodule

// File: rtl/tau_gemm_sched.sv
// Round-robin scheduler sharing one DIM x DIM tau_mac GEMM array among NUM_REQ requesters.
// Job flow: IDLE -> CLEAR (one accumulator clear) -> RUN (klen steps) -> RESP -> IDLE.
// Optional feature macro: TAU_SCHED_STEP_DONE_HS_EN ends each step on arr_step_done
// instead of a fixed STEP_CYCLES window.
module tau_gemm_sched
  import tau_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DIM         = 16,
  parameter int WIDTH       = 8,
  parameter int STEP_CYCLES = WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  tau_gemm_sched_if.master   bus
);

  localparam int RW  = req_w(NUM_REQ);
  localparam int KIW = kidx_w(DIM);
  localparam int KLW = klen_w(DIM);

  sched_state_t   state_r, state_nxt_s;
  logic [RW-1:0]  rr_ptr_r, rr_ptr_nxt_s;
  logic [RW-1:0]  sel_r, sel_nxt_s;
  logic [KLW-1:0] klen_r, klen_nxt_s;
  logic [KIW-1:0] step_r, step_nxt_s;
  logic           clear_r, start_r, rsp_valid_r, busy_r;
  logic           clear_nxt_s, start_nxt_s, rsp_valid_nxt_s, busy_nxt_s;
  logic           any_grant_s, accept_s, step_end_s, last_step_s;
  logic [RW-1:0]  grant_idx_s;
  logic [NUM_REQ-1:0] grant_oh_s;
`ifndef TAU_SCHED_STEP_DONE_HS_EN
  localparam int CW = cyc_w(STEP_CYCLES);
  logic [CW-1:0]  cyc_r, cyc_nxt_s;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .REQ_W   (RW)
  ) u_arb (
    .req       (bus.req_valid),
    .rr_ptr    (rr_ptr_r),
    .any_grant (any_grant_s),
    .grant_idx (grant_idx_s),
    .grant_oh  (grant_oh_s)
  );

  assign accept_s    = any_grant_s && (state_r == IDLE);
  assign last_step_s = (KLW'(step_r) == (klen_r - KLW'(1)));
`ifdef TAU_SCHED_STEP_DONE_HS_EN
  // A done seen in the start cycle belongs to the previous step and is ignored.
  assign step_end_s  = bus.arr_step_done && !start_r;
`else
  assign step_end_s  = (cyc_r == CW'(STEP_CYCLES - 1));
`endif

  // Next-state, job bookkeeping and next values of the registered outputs.
  always_comb begin
    state_nxt_s  = state_r;
    rr_ptr_nxt_s = rr_ptr_r;
    sel_nxt_s    = sel_r;
    klen_nxt_s   = klen_r;
    step_nxt_s   = step_r;
`ifndef TAU_SCHED_STEP_DONE_HS_EN
    cyc_nxt_s    = cyc_r;
`endif
    start_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          sel_nxt_s   = grant_idx_s;
          klen_nxt_s  = bus.req_klen[grant_idx_s];
          step_nxt_s  = {KIW{1'b0}};
          state_nxt_s = CLEAR;
          if (grant_idx_s == RW'(NUM_REQ - 1)) begin
            rr_ptr_nxt_s = {RW{1'b0}};
          end else begin
            rr_ptr_nxt_s = grant_idx_s + RW'(1);
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CLEAR: begin
`ifndef TAU_SCHED_STEP_DONE_HS_EN
        cyc_nxt_s = {CW{1'b0}};
`endif
        if (klen_r != {KLW{1'b0}}) begin
          state_nxt_s = RUN;
          start_nxt_s = 1'b1;
        end else begin
          state_nxt_s = RESP;
        end
      end
      RUN: begin
        if (step_end_s) begin
          if (last_step_s) begin
            state_nxt_s = RESP;
          end else begin
            step_nxt_s  = step_r + KIW'(1);
            start_nxt_s = 1'b1;
`ifndef TAU_SCHED_STEP_DONE_HS_EN
            cyc_nxt_s   = {CW{1'b0}};
`endif
          end
        end else begin
`ifndef TAU_SCHED_STEP_DONE_HS_EN
          cyc_nxt_s = cyc_r + CW'(1);
`endif
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    clear_nxt_s     = (state_nxt_s == CLEAR);
    rsp_valid_nxt_s = (state_nxt_s == RESP);
    busy_nxt_s      = (state_nxt_s != IDLE);
  end

  // State and output registers; reset aborts any job without a response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      rr_ptr_r    <= {RW{1'b0}};
      sel_r       <= {RW{1'b0}};
      klen_r      <= {KLW{1'b0}};
      step_r      <= {KIW{1'b0}};
`ifndef TAU_SCHED_STEP_DONE_HS_EN
      cyc_r       <= {CW{1'b0}};
`endif
      clear_r     <= 1'b0;
      start_r     <= 1'b0;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      rr_ptr_r    <= rr_ptr_nxt_s;
      sel_r       <= sel_nxt_s;
      klen_r      <= klen_nxt_s;
      step_r      <= step_nxt_s;
`ifndef TAU_SCHED_STEP_DONE_HS_EN
      cyc_r       <= cyc_nxt_s;
`endif
      clear_r     <= clear_nxt_s;
      start_r     <= start_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  assign bus.req_ready = (state_r == IDLE) ? grant_oh_s : {NUM_REQ{1'b0}};
  assign bus.arr_sel   = sel_r;
  assign bus.arr_k_idx = step_r;
  assign bus.arr_clear = clear_r;
  assign bus.arr_start = start_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = sel_r;
  assign bus.busy      = busy_r;

endmodule
